// File: rtl/rs_csee_ctrl.sv
// Stage-3 sequencer for the RS Chien-search / error-evaluation engine: buffers
// key-equation results, launches 24-beat sweeps, forwards beats, reports status.
module rs_csee_ctrl #(
  parameter int ITERATION = 24,
  parameter int SETTLE    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rs_ena,
  input  logic        kes_valid,
  output logic        kes_ready,
  input  logic [7:0]  kes_lambda0,
  input  logic [7:0]  kes_lambda1,
  input  logic [7:0]  kes_lambda2,
  input  logic [7:0]  kes_omega0,
  input  logic [7:0]  kes_omega1,
  output logic        csee_ena,
  output logic [7:0]  csee_lambda0,
  output logic [7:0]  csee_lambda1,
  output logic [7:0]  csee_lambda2,
  output logic [7:0]  csee_omega0,
  output logic [7:0]  csee_omega1,
  input  logic        csee_ongo,
  input  logic [63:0] csee_errdata,
  input  logic [11:0] csee_syncbit,
  input  logic        csee_fail,
  output logic        out_valid,
  output logic [4:0]  out_beat,
  output logic        out_last,
  output logic [63:0] out_errdata,
  output logic [11:0] out_syncbit,
  output logic        stat_valid,
  output logic        stat_fail,
  output logic        ctrl_halt,
  output logic        proto_err
);

  typedef struct packed {
    logic [7:0] l0, l1, l2, o0, o1;
  } coef_t;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_REPORT, S_HALT} state_t;

  localparam logic [4:0] BEAT_LAST = 5'(ITERATION - 1);
  localparam logic [4:0] SET_LAST  = 5'(SETTLE - 1);

  state_t     state, nxt;
  logic [4:0] cnt;
  coef_t      kes_c, act_q, pend_q, drv;
  logic       act_full, pend_full, fail_q;
  logic       en, launch, launch_rep, kes_acc;

  assign kes_c      = {kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1};
  assign en         = rstn & rs_ena;
  // Launch either from IDLE or straight out of a passing REPORT with PEND waiting.
  assign launch_rep = (state == S_REPORT) & ~fail_q & pend_full;
  assign launch     = en & (((state == S_IDLE) & act_full) | launch_rep);
  assign kes_acc    = kes_valid & kes_ready;

  always_ff @(posedge clk) begin : state_reg
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin : next_state
    nxt = state;
    case (state)
      S_IDLE:   if (act_full) nxt = S_RUN;
      S_RUN:    if (cnt == BEAT_LAST) nxt = S_SETTLE;
      S_SETTLE: if (cnt == SET_LAST) nxt = S_REPORT;
      S_REPORT: nxt = fail_q ? S_HALT : (pend_full ? S_RUN : S_IDLE);
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
    if (!rs_ena) nxt = S_IDLE;
  end

  always_comb begin : outputs
    kes_ready  = en & ~pend_full & (state != S_HALT);
    csee_ena   = launch;
    stat_valid = (state == S_REPORT);
    stat_fail  = (state == S_REPORT) & fail_q;
    ctrl_halt  = (state == S_HALT);
    drv        = '0;
    if (launch & launch_rep) drv = pend_q;
    else if (act_full)       drv = act_q;
  end

  assign csee_lambda0 = drv.l0;
  assign csee_lambda1 = drv.l1;
  assign csee_lambda2 = drv.l2;
  assign csee_omega0  = drv.o0;
  assign csee_omega1  = drv.o1;

  always_ff @(posedge clk) begin : datapath
    if (!en) begin
      cnt         <= '0;
      act_q       <= '0;
      pend_q      <= '0;
      act_full    <= 1'b0;
      pend_full   <= 1'b0;
      fail_q      <= 1'b0;
      proto_err   <= 1'b0;
      out_valid   <= 1'b0;
      out_beat    <= '0;
      out_last    <= 1'b0;
      out_errdata <= '0;
      out_syncbit <= '0;
    end else begin
      if (launch)                 cnt <= 5'd1;
      else if (state == S_RUN)    cnt <= (cnt == BEAT_LAST) ? '0 : cnt + 5'd1;
      else if (state == S_SETTLE) cnt <= cnt + 5'd1;
      else                        cnt <= '0;

      if (state == S_SETTLE && cnt == SET_LAST) fail_q <= csee_fail;
      if (state == S_RUN && !csee_ongo) proto_err <= 1'b1;

      // Beat 0 is captured in the launch cycle, beats 1.. during RUN.
      out_valid   <= launch | (state == S_RUN);
      out_beat    <= (state == S_RUN) ? cnt : '0;
      out_last    <= (state == S_RUN) && (cnt == BEAT_LAST);
      out_errdata <= (launch | (state == S_RUN)) ? csee_errdata : '0;
      out_syncbit <= launch ? csee_syncbit : '0;

      if (state == S_REPORT && !fail_q) begin
        if (pend_full) begin
          act_q     <= pend_q;
          pend_full <= 1'b0;
        end else if (kes_acc) begin
          act_q     <= kes_c;
        end else begin
          act_full  <= 1'b0;
        end
      end else if (kes_acc) begin
        if (state == S_IDLE && !act_full) begin
          act_q     <= kes_c;
          act_full  <= 1'b1;
        end else begin
          pend_q    <= kes_c;
          pend_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_csee_ctrl.sv
// Bench for rs_csee_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a launch-time-offset model.
module tb_rs_csee_ctrl;

  typedef struct packed {
    logic [7:0] l0, l1, l2, o0, o1;
  } coef_t;

  logic        clk = 1'b0;
  logic        rstn, rs_ena, kes_valid, kes_ready;
  logic [7:0]  kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1;
  logic        csee_ena;
  logic [7:0]  csee_lambda0, csee_lambda1, csee_lambda2, csee_omega0, csee_omega1;
  logic        csee_ongo, csee_fail;
  logic [63:0] csee_errdata;
  logic [11:0] csee_syncbit;
  logic        out_valid, out_last, stat_valid, stat_fail, ctrl_halt, proto_err;
  logic [4:0]  out_beat;
  logic [63:0] out_errdata;
  logic [11:0] out_syncbit;

  always #5 clk = ~clk;

  rs_csee_ctrl dut (
    .clk(clk), .rstn(rstn), .rs_ena(rs_ena),
    .kes_valid(kes_valid), .kes_ready(kes_ready),
    .kes_lambda0(kes_lambda0), .kes_lambda1(kes_lambda1), .kes_lambda2(kes_lambda2),
    .kes_omega0(kes_omega0), .kes_omega1(kes_omega1),
    .csee_ena(csee_ena),
    .csee_lambda0(csee_lambda0), .csee_lambda1(csee_lambda1), .csee_lambda2(csee_lambda2),
    .csee_omega0(csee_omega0), .csee_omega1(csee_omega1),
    .csee_ongo(csee_ongo), .csee_errdata(csee_errdata), .csee_syncbit(csee_syncbit),
    .csee_fail(csee_fail),
    .out_valid(out_valid), .out_beat(out_beat), .out_last(out_last),
    .out_errdata(out_errdata), .out_syncbit(out_syncbit),
    .stat_valid(stat_valid), .stat_fail(stat_fail),
    .ctrl_halt(ctrl_halt), .proto_err(proto_err)
  );

  int n_pass = 0, n_tot = 0, cyc = 0;
  bit started = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) started <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: each launched codeword is tracked by its launch cycle; every output
  // follows from the offset into the 26-cycle sweep/settle/report window.
  coef_t       wq[$];
  coef_t       cur_c;
  bit          cur_v = 0, halted = 0, proto = 0, curfail = 0;
  int          cur_T = 0;
  logic        e_ov = 0, e_last = 0;
  logic [4:0]  e_beat = 0;
  logic [63:0] e_err = 0;
  logic [11:0] e_sync = 0;

  always @(negedge clk) begin : model
    int    o;
    bit    rep, launch, exp_ready, acc, busy;
    coef_t ec, kc;
    o         = cur_v ? cyc - cur_T : -1;
    rep       = cur_v && !halted && o == 26;
    busy      = cur_v && !halted && o >= 1 && o <= 23;
    launch    = rstn && rs_ena && wq.size() > 0 && (!cur_v || (rep && !curfail));
    exp_ready = rstn && rs_ena && !halted && (int'(cur_v) + wq.size() < 2);
    ec        = launch ? wq[0] : (cur_v ? cur_c : (wq.size() > 0 ? wq[0] : '0));
    if (started) begin
      chk("kes_ready", kes_ready, exp_ready);
      chk("csee_ena", csee_ena, launch);
      chk("csee_coef", {csee_lambda0, csee_lambda1, csee_lambda2, csee_omega0, csee_omega1}, ec);
      chk("out_valid", out_valid, e_ov);
      chk("out_beat", out_beat, e_beat);
      chk("out_last", out_last, e_last);
      chk("out_errdata", out_errdata, e_err);
      chk("out_syncbit", out_syncbit, e_sync);
      chk("stat_valid", stat_valid, rep);
      chk("stat_fail", stat_fail, rep && curfail);
      chk("ctrl_halt", ctrl_halt, halted);
      chk("proto_err", proto_err, proto);
    end
    if (!rstn || !rs_ena) begin
      wq.delete();
      cur_v = 0; halted = 0; proto = 0; curfail = 0;
      e_ov = 0; e_beat = 0; e_last = 0; e_err = 0; e_sync = 0;
    end else begin
      acc = kes_valid && exp_ready;
      kc  = {kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1};
      if (launch) begin
        e_ov = 1; e_beat = 0; e_last = 0; e_err = csee_errdata; e_sync = csee_syncbit;
      end else if (busy) begin
        e_ov = 1; e_beat = 5'(o); e_last = (o == 23); e_err = csee_errdata; e_sync = 0;
      end else begin
        e_ov = 0; e_beat = 0; e_last = 0; e_err = 0; e_sync = 0;
      end
      if (busy && !csee_ongo) proto = 1;
      if (cur_v && !halted && o == 25) curfail = csee_fail;
      if (rep) begin
        if (curfail) halted = 1;
        else cur_v = 0;
      end
      if (launch) begin
        cur_c = wq.pop_front(); cur_v = 1; cur_T = cyc; curfail = 0;
      end
      if (acc) wq.push_back(kc);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_kes(input coef_t c);
    kes_lambda0 = c.l0; kes_lambda1 = c.l1; kes_lambda2 = c.l2;
    kes_omega0  = c.o0; kes_omega1  = c.o1;
  endtask

  // Offers one result and returns in the cycle after acceptance.
  task automatic offer(input coef_t c);
    bit ok = 0;
    set_kes(c);
    kes_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (kes_ready) ok = 1;
      tick();
    end
    kes_valid = 1'b0;
    if (!ok) chk("offer_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    coef_t cb;
    rstn = 0; rs_ena = 1; kes_valid = 0; set_kes('0);
    csee_ongo = 1; csee_errdata = '0; csee_syncbit = '0; csee_fail = 0;
    repeat (2) tick();
    #1;
    chk("rst_ready", kes_ready, 1'b0);
    chk("rst_ena", csee_ena, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    tick();
    rstn = 1;
    tick();

    // Single codeword, syncbit and last-beat errdata placement.
    offer({8'd1, 8'd0, 8'd0, 8'd0, 8'd0});
    for (int k = 0; k <= 27; k++) begin
      csee_syncbit = (k == 0) ? 12'hABC : (k == 5) ? 12'h123 : 12'h0;
      csee_errdata = (k == 23) ? 64'h1 : 64'h0;
      #1;
      if (k == 0)  begin chk("t1_ena", csee_ena, 1'b1); chk("t1_lam0", csee_lambda0, 8'd1); end
      if (k == 1)  begin chk("t1_v1", out_valid, 1'b1); chk("t1_sync", out_syncbit, 12'hABC); end
      if (k == 6)  begin chk("t1_sync5", out_syncbit, 12'h0); chk("t1_beat5", out_beat, 5'd5); end
      if (k == 24) begin chk("t1_last", out_last, 1'b1); chk("t1_err23", out_errdata, 64'h1); end
      if (k == 25) chk("t1_v25", out_valid, 1'b0);
      if (k == 26) begin chk("t1_stat", stat_valid, 1'b1); chk("t1_fail", stat_fail, 1'b0); end
      tick();
    end
    csee_syncbit = '0; csee_errdata = '0;

    // Back-to-back: second result waits in PEND, launches exactly at T+26.
    offer({8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    cb = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    set_kes(cb); kes_valid = 1;
    #1;
    chk("t2_ena", csee_ena, 1'b1);
    chk("t2_ready0", kes_ready, 1'b1);
    tick();
    set_kes({8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E});
    for (int k = 1; k <= 27; k++) begin
      #1;
      if (k == 5)  chk("t2_full", kes_ready, 1'b0);
      if (k == 25) chk("t2_noearly", csee_ena, 1'b0);
      if (k == 26) begin
        chk("t2_ena26", csee_ena, 1'b1);
        chk("t2_stat26", stat_valid, 1'b1);
        chk("t2_lam26", csee_lambda0, 8'hA1);
      end
      tick();
    end
    kes_valid = 0;
    repeat (60) tick();

    // Failure: halt, then one cycle of rs_ena low recovers.
    offer({8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    for (int k = 0; k <= 28; k++) begin
      csee_fail = (k == 25);
      #1;
      if (k == 26) begin chk("t3_stat", stat_valid, 1'b1); chk("t3_fail", stat_fail, 1'b1); end
      if (k == 27) begin chk("t3_halt", ctrl_halt, 1'b1); chk("t3_ready", kes_ready, 1'b0); end
      tick();
    end
    csee_fail = 0; rs_ena = 0;
    tick();
    rs_ena = 1;
    #1;
    chk("t3_unhalt", ctrl_halt, 1'b0);
    tick();

    // Abort mid-sweep.
    offer({8'h10, 8'h20, 8'h30, 8'h40, 8'h50});
    for (int k = 0; k <= 40; k++) begin
      rs_ena = (k != 10);
      #1;
      if (k == 11) chk("t4_valid", out_valid, 1'b0);
      if (k == 12) chk("t4_ena", csee_ena, 1'b0);
      if (k == 26) chk("t4_stat", stat_valid, 1'b0);
      tick();
    end

    // Engine drops ongo mid-sweep: sticky flag, sequencing unchanged.
    offer({8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B});
    for (int k = 0; k <= 27; k++) begin
      csee_ongo = (k != 7);
      #1;
      if (k == 8)  chk("t5_proto", proto_err, 1'b1);
      if (k == 24) begin chk("t5_v23", out_valid, 1'b1); chk("t5_b23", out_beat, 5'd23); end
      if (k == 26) chk("t5_stat", stat_valid, 1'b1);
      tick();
    end
    csee_ongo = 1; rs_ena = 0;
    tick();
    rs_ena = 1;
    #1;
    chk("t5_clear", proto_err, 1'b0);
    tick();

    // Random traffic, checked by the model every cycle.
    repeat (4000) begin
      rstn         = ($urandom_range(0, 499) != 0);
      rs_ena       = ($urandom_range(0, 149) != 0);
      kes_valid    = ($urandom_range(0, 2) == 0);
      set_kes({$urandom, 8'($urandom)});
      csee_ongo    = ($urandom_range(0, 63) != 0);
      csee_errdata = {$urandom, $urandom};
      csee_syncbit = 12'($urandom);
      csee_fail    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
